// File: rtl/serial_addsub_acc.sv
// Serial add/subtract accumulator: CHUNK bits per BUSY cycle, W/CHUNK cycles per add/sub.
// One command per valid/ready handshake; acc and flags commit together at the end.
module serial_addsub_acc #(
  parameter int W     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] operand,
  output logic [W-1:0] acc,
  output logic         out_valid,
  output logic         busy,
  output logic         carry,
  output logic         of,
  output logic         zero,
  output logic         sticky_of
);

  localparam int N  = W / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [W-1:0]      acc_r;
  logic              carry_r;
  logic              of_r;
  logic              sticky_r;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic [W-1:0]      part_r;
  logic              cin_r;
  logic [CW-1:0]     cnt_r;

  logic              accept_s;
  logic              last_s;
  logic [CHUNK:0]    sum_s;
  logic              of_new_s;
  logic [W-1:0]      part_next_s;
  logic [W+CHUNK-1:0] part_ext_s;

  assign accept_s = in_valid && (state_r == S_IDLE);
  assign last_s   = (cnt_r == CW'(N - 1));

  // One chunk of the ripple sum; of uses the carry into the top bit of the last chunk.
  assign sum_s       = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin_r};
  assign of_new_s    = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ sum_s[CHUNK-1] ^ sum_s[CHUNK];
  assign part_ext_s  = {sum_s[CHUNK-1:0], part_r};
  assign part_next_s = W'(part_ext_s >> CHUNK);

  assign in_ready  = (state_r == S_IDLE);
  assign busy      = (state_r == S_BUSY);
  assign out_valid = (state_r == S_DONE);
  assign acc       = acc_r;
  assign carry     = carry_r;
  assign of        = of_r;
  assign sticky_of = sticky_r;
  assign zero      = (acc_r == {W{1'b0}});

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if ((op == OP_ADD) || (op == OP_SUB)) begin
            state_next_s = S_BUSY;
          end else begin
            state_next_s = S_DONE;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (last_s) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_BUSY;
        end
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Datapath: command latch, serial chunk steps, and the commit of acc/flags.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      acc_r    <= {W{1'b0}};
      carry_r  <= 1'b0;
      of_r     <= 1'b0;
      sticky_r <= 1'b0;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      part_r   <= {W{1'b0}};
      cin_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else if (accept_s) begin
      case (op)
        OP_LOAD: begin
          acc_r   <= operand;
          carry_r <= 1'b0;
          of_r    <= 1'b0;
        end
        OP_CLEAR: begin
          acc_r    <= {W{1'b0}};
          carry_r  <= 1'b0;
          of_r     <= 1'b0;
          sticky_r <= 1'b0;
        end
        OP_ADD, OP_SUB: begin
          a_r    <= acc_r;
          b_r    <= (op == OP_SUB) ? ~operand : operand;
          cin_r  <= (op == OP_SUB);
          part_r <= {W{1'b0}};
          cnt_r  <= {CW{1'b0}};
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end else if (state_r == S_BUSY) begin
      a_r    <= a_r >> CHUNK;
      b_r    <= b_r >> CHUNK;
      part_r <= part_next_s;
      cin_r  <= sum_s[CHUNK];
      cnt_r  <= cnt_r + CW'(1);
      if (last_s) begin
        acc_r    <= part_next_s;
        carry_r  <= sum_s[CHUNK];
        of_r     <= of_new_s;
        sticky_r <= sticky_r | of_new_s;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_acc.sv
// Directed bench for serial_addsub_acc: 8-bit/2-bit-chunk instance with a
// reference model and scoreboard queue, plus a 4-bit single-chunk instance.
module tb_serial_addsub_acc;

  logic       clk = 1'b0;
  logic       clr;
  logic       in_valid, in_ready, out_valid, busy, carry, of, zero, sticky_of;
  logic [1:0] op;
  logic [7:0] operand, acc;

  logic       in_valid4, in_ready4, out_valid4, busy4, carry4, of4, zero4, sticky4;
  logic [1:0] op4;
  logic [3:0] operand4, acc4;

  always #5 clk = ~clk;

  serial_addsub_acc #(.W(8), .CHUNK(2)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand(operand), .acc(acc), .out_valid(out_valid), .busy(busy),
    .carry(carry), .of(of), .zero(zero), .sticky_of(sticky_of)
  );

  serial_addsub_acc #(.W(4), .CHUNK(4)) dut4 (
    .clk(clk), .clr(clr), .in_valid(in_valid4), .in_ready(in_ready4), .op(op4),
    .operand(operand4), .acc(acc4), .out_valid(out_valid4), .busy(busy4),
    .carry(carry4), .of(of4), .zero(zero4), .sticky_of(sticky4)
  );

  typedef struct {
    logic [7:0] acc;
    logic       carry;
    logic       of;
    logic       sticky;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] m_acc = 8'h00;
  logic       m_carry = 1'b0, m_of = 1'b0, m_sticky = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: plain 9-bit add, sign-rule overflow.
  task automatic model_push(input logic [1:0] o, input logic [7:0] v);
    logic [7:0] bp;
    logic [8:0] s9;
    exp_t       e;
    case (o)
      2'b00: begin m_acc = v; m_carry = 1'b0; m_of = 1'b0; end
      2'b11: begin m_acc = 8'h00; m_carry = 1'b0; m_of = 1'b0; m_sticky = 1'b0; end
      default: begin
        bp = (o == 2'b10) ? ~v : v;
        s9 = {1'b0, m_acc} + {1'b0, bp} + ((o == 2'b10) ? 9'd1 : 9'd0);
        m_of = (m_acc[7] == bp[7]) && (s9[7] != m_acc[7]);
        m_carry = s9[8];
        m_acc = s9[7:0];
        m_sticky = m_sticky | m_of;
      end
    endcase
    e.acc = m_acc; e.carry = m_carry; e.of = m_of; e.sticky = m_sticky;
    e.lat = (o == 2'b01 || o == 2'b10) ? 5 : 1;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_acc"}, {24'd0, acc}, {24'd0, e.acc});
      chk({tag, "_carry"}, {31'd0, carry}, {31'd0, e.carry});
      chk({tag, "_of"}, {31'd0, of}, {31'd0, e.of});
      chk({tag, "_sticky"}, {31'd0, sticky_of}, {31'd0, e.sticky});
      chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (e.acc == 8'h00)});
      chk({tag, "_lat"}, lat, e.lat);
    end
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] o, input logic [7:0] v);
    logic [7:0] prev;
    int         lat;
    bit         seen;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; operand = v;
    prev = m_acc;
    @(posedge clk);
    model_push(o, v);
    seen = 1'b0;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (lat == 1) in_valid = 1'b0;
      if (out_valid) begin
        seen = 1'b1;
        check_out(tag, lat);
        break;
      end else begin
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hold"}, {24'd0, acc}, {24'd0, prev});
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int cyc, outs, accepts, last_acc, lat;
    clr = 1'b0; in_valid = 1'b0; op = 2'b00; operand = 8'h00;
    in_valid4 = 1'b0; op4 = 2'b00; operand4 = 4'h0;
    #12;
    chk("rst_acc", {24'd0, acc}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_flags", {28'd0, carry, of, sticky_of, out_valid}, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    do_cmd("load7f", 2'b00, 8'h7F);
    do_cmd("add01", 2'b01, 8'h01);
    do_cmd("load03", 2'b00, 8'h03);
    do_cmd("sub05", 2'b10, 8'h05);
    do_cmd("subfe", 2'b10, 8'hFE);
    do_cmd("clear", 2'b11, 8'hAA);

    // Back-to-back: in_valid held high, one accept per 6 cycles.
    @(negedge clk);
    in_valid = 1'b1; op = 2'b01; operand = 8'h10;
    cyc = 0; outs = 0; accepts = 0; last_acc = 0;
    while (outs < 3 && cyc < 60) begin
      if (out_valid) begin
        check_out("stream", cyc - last_acc);
        outs++;
        if (outs == 3) in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (accepts > 0) chk("stream_gap", cyc - last_acc, 6);
        model_push(2'b01, 8'h10);
        accepts++;
        last_acc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    chk("stream_accepts", accepts, 3);
    chk("stream_outs", outs, 3);
    chk("stream_idle", {31'd0, in_ready}, 32'd1);

    // Abort an add with clr in its second BUSY cycle.
    do_cmd("load01", 2'b00, 8'h01);
    @(negedge clk);
    in_valid = 1'b1; op = 2'b01; operand = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    clr = 1'b0;
    #1;
    chk("abort_acc", {24'd0, acc}, 32'd0);
    chk("abort_state", {29'd0, busy, in_ready, out_valid}, 32'b010);
    chk("abort_flags", {29'd0, carry, of, sticky_of}, 32'd0);
    m_acc = 8'h00; m_carry = 1'b0; m_of = 1'b0; m_sticky = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    outs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) outs++;
    end
    chk("abort_no_pulse", outs, 0);
    do_cmd("load55", 2'b00, 8'h55);
    chk("sb_drained", sb.size(), 0);

    // Single-chunk instance: 7 + 1 in 4 bits.
    @(negedge clk);
    in_valid4 = 1'b1; op4 = 2'b00; operand4 = 4'h7;
    @(negedge clk);
    in_valid4 = 1'b0;
    chk("w4_load", {27'd0, out_valid4, acc4}, {27'd1, 4'h7});
    @(negedge clk);
    in_valid4 = 1'b1; op4 = 2'b01; operand4 = 4'h1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) in_valid4 = 1'b0;
      if (out_valid4) begin
        lat = i;
        break;
      end
    end
    chk("w4_lat", lat, 2);
    chk("w4_acc", {28'd0, acc4}, 32'h8);
    chk("w4_flags", {28'd0, carry4, of4, sticky4, zero4}, 32'b0110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub_acc.md
Name: serial_addsub_acc

Overview:
Parametrised W-bit signed/unsigned add/subtract accumulator. It processes CHUNK bits per clock, the same way chained 2-bit adder slices ripple one digit at a time. It accepts one command per valid/ready handshake, holds the running result in an internal accumulator register, and reports carry, overflow, zero and sticky-overflow flags. It sits between the switch/button input adapter and the LED output adapter.

Parameters:
W, 8, accumulator/operand width in bits; must be a multiple of CHUNK.
CHUNK, 2, bits added per BUSY cycle; N = W/CHUNK BUSY cycles per add/sub.

Ports:
clk  in  1  clock, rising edge.
clr  in  1  reset, asynchronous, active-low.
in_valid  in  1  command present.
in_ready  out  1  block can accept a command; 1 only in IDLE.
op  in  2  00 load, 01 add, 10 sub, 11 clear.
operand  in  W  B operand; ignored for clear.
acc  out  W  accumulator value.
out_valid  out  1  one-cycle pulse: command completed, acc/flags updated.
busy  out  1  1 in BUSY state.
carry  out  1  carry out of the MSB from the last add/sub; for sub, 1 = no borrow.
of  out  1  two's-complement overflow of the last add/sub.
zero  out  1  acc == 0, combinational from acc.
sticky_of  out  1  set by any add/sub with of=1; cleared only by clear op or reset.

Behaviour:
- Reset (clr=0, async): state=IDLE, acc=0, carry=0, of=0, sticky_of=0, out_valid=0, internal shift/partial registers=0. zero=1, in_ready=1 while in reset.
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept: at a rising edge with in_valid & in_ready, the block latches op and operand. in_valid outside IDLE is ignored; commands are never queued.
- load: acc <= operand, carry <= 0, of <= 0, sticky_of unchanged; next state DONE.
- clear: acc, carry, of and sticky_of <= 0; next state DONE.
- add/sub setup on accept:
  - Latch A = acc.
  - Latch B' = operand for add, ~operand for sub.
  - Set cin = 0 for add, 1 for sub.
  - Set chunk counter = 0; next state BUSY.
- BUSY, each edge:
  - Add the low CHUNK bits of A, B' and the running carry.
  - Shift the CHUNK-bit sum into the partial result from the MSB side.
  - Shift A and B' right by CHUNK.
  - Store the carry out; increment the counter.
- BUSY completion: on the N-th BUSY edge:
  - acc <= full W-bit result.
  - carry <= carry out of bit W-1.
  - of <= carry into bit W-1 XOR carry out of bit W-1.
  - sticky_of <= sticky_of | of_new.
  - Next state DONE.
- acc and the flags hold their old values throughout BUSY and change only at the commit edge.
- DONE lasts exactly one cycle, then IDLE.
- Latency:
  - load/clear: accept edge e0, out_valid high in the cycle after e0, in_ready returns after e1.
  - add/sub: accept e0, commit at eN, out_valid high in the cycle after eN, in_ready=1 after eN+1.
  - Throughput is one add/sub per N+2 cycles.
- Arithmetic: modulo 2^W, no saturation. The carry and of definitions are identical to a W-bit ripple adder with K-controlled operand inversion.
- Reset mid-operation: an async clr during BUSY or DONE aborts the command with no commit; all outputs go to their reset values immediately.
- CHUNK == W: BUSY lasts exactly 1 cycle.

Test Plan:
- W=8, CHUNK=2: reset -> acc=0x00, zero=1, in_ready=1, carry=of=sticky_of=0. load 0x7F -> out_valid 1 cycle after accept, acc=0x7F, zero=0.
- From acc=0x7F, add 0x01 -> busy for 4 cycles, acc stays 0x7F while busy; out_valid in cycle 5 after accept; acc=0x80, of=1, carry=0, sticky_of=1.
- From acc=0x03, sub 0x05 -> acc=0xFE, carry=0 (borrow), of=0. Then sub 0xFE -> acc=0x00, carry=1, zero=1, sticky_of unchanged.
- Hold in_valid=1 with add 0x10 continuously from acc=0x00 -> exactly one command accepted per 6 cycles; acc steps 0x10, 0x20, 0x30; no command is lost or double-counted inside BUSY/DONE.
- Start add 0xFF from acc=0x01, assert clr at BUSY cycle 2 -> acc=0, state IDLE, out_valid never pulses; the next load 0x55 works normally.
- With sticky_of=1, issue clear -> acc=0, sticky_of=0, out_valid 1 cycle after accept. Rerun with W=4, CHUNK=4: 7+1 -> acc=0x8, of=1, out_valid 2 cycles after accept.
